counter_sched: RTL and testbench



---
 rtl/counter_sched.sv | 131 +++++++++++++
 tb/tb_counter_sched.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sched.sv
// counter_sched: round-robin scheduler sharing one down-counting interval
// counter between two requesters. Optional abort support is enabled by
// defining COUNTER_SCHED_ABORT_EN (adds input abort / output aborted).
module counter_sched #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             req0,
   input  logic [WIDTH-1:0] len0,
   input  logic             req1,
   input  logic [WIDTH-1:0] len1,
`ifdef COUNTER_SCHED_ABORT_EN
   input  logic             abort,
   output logic             aborted,
`endif
   output logic             gnt0,
   output logic             gnt1,
   output logic             busy,
   output logic [WIDTH-1:0] count,
   output logic             done0,
   output logic             done1
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic             last, last_nx;
   logic             gnt0_nx, gnt1_nx, done0_nx, done1_nx, busy_nx;
   logic [WIDTH-1:0] count_nx;
   logic             win1;
`ifdef COUNTER_SCHED_ABORT_EN
   logic             aborted_nx;
`endif

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_nx = state;
      last_nx  = last;
      gnt0_nx  = gnt0;
      gnt1_nx  = gnt1;
      done0_nx = 1'b0;
      done1_nx = 1'b0;
      count_nx = count;
      win1     = 1'b0;
`ifdef COUNTER_SCHED_ABORT_EN
      aborted_nx = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               // On a tie the requester that was not served last wins.
               win1     = req1 && (!req0 || !last);
               last_nx  = win1;
               gnt0_nx  = !win1;
               gnt1_nx  = win1;
               count_nx = win1 ? len1 : len0;
               if (count_nx == '0) begin
                  state_nx = DONE;
                  done0_nx = !win1;
                  done1_nx = win1;
               end else begin
                  state_nx = RUN;
               end
            end
         end
         RUN: begin
`ifdef COUNTER_SCHED_ABORT_EN
            if (abort) begin
               // Count is left frozen so the owner can see how far it got.
               state_nx   = DONE;
               done0_nx   = gnt0;
               done1_nx   = gnt1;
               aborted_nx = 1'b1;
            end else
`endif
            if (count <= WIDTH'(1)) begin
               count_nx = '0;
               state_nx = DONE;
               done0_nx = gnt0;
               done1_nx = gnt1;
            end else begin
               count_nx = count - WIDTH'(1);
            end
         end
         DONE: begin
            state_nx = IDLE;
            gnt0_nx  = 1'b0;
            gnt1_nx  = 1'b0;
            count_nx = '0;
         end
         default: begin
            state_nx = IDLE;
            gnt0_nx  = 1'b0;
            gnt1_nx  = 1'b0;
            count_nx = '0;
         end
      endcase
      busy_nx = (state_nx != IDLE);
   end

   // State and registered outputs; clear wins over everything.
   always_ff @(posedge clock) begin
      if (clear) begin
         state <= IDLE;
         last  <= 1'b1;
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         busy  <= 1'b0;
         count <= '0;
`ifdef COUNTER_SCHED_ABORT_EN
         aborted <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         last  <= last_nx;
         gnt0  <= gnt0_nx;
         gnt1  <= gnt1_nx;
         done0 <= done0_nx;
         done1 <= done1_nx;
         busy  <= busy_nx;
         count <= count_nx;
`ifdef COUNTER_SCHED_ABORT_EN
         aborted <= aborted_nx;
`endif
      end
   end

endmodule

// File: tb/tb_counter_sched.sv
// Testbench for counter_sched: vector table, directed corner sequences and
// randomized requesters checked against a timeline-based reference model.
module tb_counter_sched;

   logic       clock = 1'b0;
   logic       clear, req0, req1;
   logic [3:0] len0, len1;
   logic       gnt0, gnt1, busy, done0, done1;
   logic [3:0] count;
`ifdef COUNTER_SCHED_ABORT_EN
   logic       abort, aborted;
`endif

   int checks   = 0;
   int failures = 0;

   counter_sched #(.WIDTH(4)) dut (
      .clock (clock),
      .clear (clear),
      .req0  (req0),
      .len0  (len0),
      .req1  (req1),
      .len1  (len1),
`ifdef COUNTER_SCHED_ABORT_EN
      .abort   (abort),
      .aborted (aborted),
`endif
      .gnt0  (gnt0),
      .gnt1  (gnt1),
      .busy  (busy),
      .count (count),
      .done0 (done0),
      .done1 (done1)
   );

   always #5 clock = ~clock;

   // Packed view {gnt0,gnt1,done0,done1,busy,count}.
   function automatic logic [8:0] o(bit g0, bit g1, bit d0, bit d1, bit b, int c);
      logic [3:0] c4;
      c4 = c[3:0];
      return {g0, g1, d0, d1, b, c4};
   endfunction

   typedef struct {
      bit         clr;
      bit         r0;
      logic [3:0] l0;
      bit         r1;
      logic [3:0] l1;
      logic [8:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(bit c, bit r0, int l0, bit r1, int l1, logic [8:0] e);
      vec_t t;
      t.clr = c; t.r0 = r0; t.l0 = l0[3:0]; t.r1 = r1; t.l1 = l1[3:0]; t.exp = e;
      return t;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [8:0] exp);
      logic [8:0] act;
      act = {gnt0, gnt1, done0, done1, busy, count};
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got g0g1d0d1b_cnt=%b required %b", name, act, exp);
      end
   endtask

   // Reference model state: who owns the counter, since which edge, what length.
   int m_own, m_last, m_k, m_len;

   function automatic logic [8:0] model_update(bit c, bit r0, int l0, bit r1, int l1);
      int w;
      if (c) begin
         m_own = -1; m_last = 1;
      end else if (m_own < 0) begin
         if (r0 || r1) begin
            w = (r0 && r1) ? (1 - m_last) : (r0 ? 0 : 1);
            m_own = w; m_last = w; m_len = w ? l1 : l0; m_k = 0;
         end
      end else begin
         m_k++;
         if (m_k > m_len) m_own = -1;
      end
      if (m_own < 0) return o(0, 0, 0, 0, 0, 0);
      return o(m_own == 0, m_own == 1, (m_own == 0) && (m_k == m_len),
               (m_own == 1) && (m_k == m_len), 1, m_len - m_k);
   endfunction

   initial begin
      logic [8:0] e;
      clear = 1'b1; req0 = 1'b0; req1 = 1'b0; len0 = '0; len1 = '0;
`ifdef COUNTER_SCHED_ABORT_EN
      abort = 1'b0;
`endif

      // ---------------- table-driven vectors ----------------
      tbl.push_back(v(1, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0)));
      tbl.push_back(v(0, 1, 3, 0, 0, o(1, 0, 0, 0, 1, 3)));
      tbl.push_back(v(0, 1, 3, 0, 0, o(1, 0, 0, 0, 1, 2)));
      tbl.push_back(v(0, 1, 3, 0, 0, o(1, 0, 0, 0, 1, 1)));
      tbl.push_back(v(0, 1, 3, 0, 0, o(1, 0, 1, 0, 1, 0)));
      tbl.push_back(v(0, 0, 3, 0, 0, o(0, 0, 0, 0, 0, 0)));
      tbl.push_back(v(0, 0, 0, 1, 0, o(0, 1, 0, 1, 1, 0)));
      tbl.push_back(v(0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0)));
      tbl.push_back(v(1, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0)));
      tbl.push_back(v(0, 1, 2, 1, 2, o(1, 0, 0, 0, 1, 2)));
      tbl.push_back(v(0, 1, 2, 1, 2, o(1, 0, 0, 0, 1, 1)));
      tbl.push_back(v(0, 1, 2, 1, 2, o(1, 0, 1, 0, 1, 0)));
      tbl.push_back(v(0, 0, 2, 1, 2, o(0, 0, 0, 0, 0, 0)));
      tbl.push_back(v(0, 0, 2, 1, 2, o(0, 1, 0, 0, 1, 2)));
      tbl.push_back(v(0, 0, 2, 1, 2, o(0, 1, 0, 0, 1, 1)));
      tbl.push_back(v(0, 0, 2, 1, 2, o(0, 1, 0, 1, 1, 0)));
      tbl.push_back(v(0, 0, 2, 0, 2, o(0, 0, 0, 0, 0, 0)));
      tbl.push_back(v(0, 1, 2, 1, 1, o(1, 0, 0, 0, 1, 2)));
      tbl.push_back(v(0, 1, 2, 1, 1, o(1, 0, 0, 0, 1, 1)));
      tbl.push_back(v(0, 1, 2, 1, 1, o(1, 0, 1, 0, 1, 0)));
      tbl.push_back(v(0, 0, 2, 1, 1, o(0, 0, 0, 0, 0, 0)));
      tbl.push_back(v(0, 0, 2, 1, 1, o(0, 1, 0, 0, 1, 1)));
      tbl.push_back(v(0, 0, 2, 1, 1, o(0, 1, 0, 1, 1, 0)));
      tbl.push_back(v(0, 0, 2, 0, 1, o(0, 0, 0, 0, 0, 0)));
      tbl.push_back(v(0, 1, 0, 0, 0, o(1, 0, 1, 0, 1, 0)));
      tbl.push_back(v(0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0)));
      tbl.push_back(v(0, 1, 1, 1, 0, o(0, 1, 0, 1, 1, 0)));
      tbl.push_back(v(0, 1, 1, 0, 0, o(0, 0, 0, 0, 0, 0)));
      tbl.push_back(v(0, 1, 1, 0, 0, o(1, 0, 0, 0, 1, 1)));
      tbl.push_back(v(0, 1, 1, 0, 0, o(1, 0, 1, 0, 1, 0)));
      tbl.push_back(v(0, 0, 1, 0, 0, o(0, 0, 0, 0, 0, 0)));

      for (int i = 0; i < tbl.size(); i++) begin
         clear = tbl[i].clr; req0 = tbl[i].r0; len0 = tbl[i].l0;
         req1 = tbl[i].r1; len1 = tbl[i].l1;
         step();
         check($sformatf("vec%0d", i), tbl[i].exp);
      end

      // ---------------- clear during RUN ----------------
      clear = 1'b1; req0 = 1'b0; req1 = 1'b0; step();
      clear = 1'b0; req0 = 1'b1; len0 = 4'd9;
      for (int n = 0; n < 5; n++) step();
      check("clr_pre", o(1, 0, 0, 0, 1, 5));
      clear = 1'b1; step();
      check("clr_abort", o(0, 0, 0, 0, 0, 0));
      clear = 1'b0; step();
      check("clr_regrant", o(1, 0, 0, 0, 1, 9));
      clear = 1'b1; req0 = 1'b0; step();

      // ---------------- req1 raised during requester 0 RUN ----------------
      clear = 1'b0; req0 = 1'b1; len0 = 4'd2; step();
      check("late_g0", o(1, 0, 0, 0, 1, 2));
      req1 = 1'b1; len1 = 4'd1; step();
      check("late_run", o(1, 0, 0, 0, 1, 1));
      step();
      check("late_done0", o(1, 0, 1, 0, 1, 0));
      req0 = 1'b0; step();
      check("late_gap", o(0, 0, 0, 0, 0, 0));
      step();
      check("late_g1", o(0, 1, 0, 0, 1, 1));
      step();
      check("late_done1", o(0, 1, 0, 1, 1, 0));
      req1 = 1'b0; step();

`ifdef COUNTER_SCHED_ABORT_EN
      // ---------------- abort mid-RUN ----------------
      clear = 1'b1; step();
      clear = 1'b0; req0 = 1'b1; len0 = 4'd8;
      for (int n = 0; n < 4; n++) step();
      check("ab_pre", o(1, 0, 0, 0, 1, 5));
      abort = 1'b1; step();
      abort = 1'b0;
      check("ab_done", o(1, 0, 1, 0, 1, 5));
      checks++;
      if (aborted !== 1'b1) begin
         failures++;
         $display("FAIL ab_flag: got aborted=%b required 1", aborted);
      end
      req0 = 1'b0; step();
      check("ab_idle", o(0, 0, 0, 0, 0, 0));
      checks++;
      if (aborted !== 1'b0) begin
         failures++;
         $display("FAIL ab_flag_clr: got aborted=%b required 0", aborted);
      end
`endif

      // ---------------- randomized requesters vs model ----------------
      clear = 1'b1; req0 = 1'b0; req1 = 1'b0;
      e = model_update(1, 0, 0, 0, 0);
      step();
      check("rnd_reset", e);
      clear = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         e = model_update(clear, req0, len0, req1, len1);
         step();
         check($sformatf("rnd%0d", c), e);
         // Requesters drop on seeing their done, otherwise may raise a new one.
         if (e[6]) req0 = 1'b0;
         else if (!req0 && ($urandom % 3 == 0)) begin
            req0 = 1'b1; len0 = 4'($urandom_range(0, 6));
         end
         if (e[5]) req1 = 1'b0;
         else if (!req1 && ($urandom % 3 == 0)) begin
            req1 = 1'b1; len1 = 4'($urandom_range(0, 6));
         end
         clear = ($urandom % 80 == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
